// File: rtl/arcsin_sched_if.sv
// Bundle of request, response and core-side signals for the arcsin scheduler.
// Pure wiring, no latency.
// The scheduler drives the master view; requesters plus the core use the slave view.
interface arcsin_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 20,
  parameter int RW    = 8
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    REQ_I;
  logic [N_REQ*DW-1:0] REQ_DATA_I;
  logic [N_REQ-1:0]    ACK_O;
  logic                RESP_VALID_O;
  logic [IW-1:0]       RESP_ID_O;
  logic [RW-1:0]       RESP_DATA_O;
  logic                RESP_ERR_O;
  logic                CORE_START_O;
  logic [DW-1:0]       CORE_DATA_O;
  logic                CORE_DONE_I;
  logic [RW-1:0]       CORE_DATA_I;
  logic                BUSY_O;

  modport master (
    input  REQ_I, REQ_DATA_I, CORE_DONE_I, CORE_DATA_I,
    output ACK_O, RESP_VALID_O, RESP_ID_O, RESP_DATA_O, RESP_ERR_O,
           CORE_START_O, CORE_DATA_O, BUSY_O
  );

  modport slave (
    output REQ_I, REQ_DATA_I, CORE_DONE_I, CORE_DATA_I,
    input  ACK_O, RESP_VALID_O, RESP_ID_O, RESP_DATA_O, RESP_ERR_O,
           CORE_START_O, CORE_DATA_O, BUSY_O
  );
endinterface

// File: rtl/arcsin_sched.sv
// Round-robin arbiter sharing one iterative arcsin core among N_REQ requesters, with a timeout watchdog.
// Latency: ACK/START one cycle after a sampled request; response one cycle after core done or timeout.
// Backpressure: requesters hold REQ until ACK; only one operation in flight, new grants only from IDLE.
module arcsin_sched #(
  parameter int N_REQ   = 4,
  parameter int DW      = 20,
  parameter int RW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  arcsin_sched_if.master bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_core_dat;
  logic [TW-1:0] r_timer;
  logic [RW-1:0] r_resp_dat;
  logic [IW-1:0] r_resp_id;
  logic          r_resp_err;

  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_cand;
  logic          w_timeout;

  assign w_timeout = (r_timer == TMAX);

  // Round-robin search starting just after the last grant; scanning downwards so the nearest candidate wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % N_REQ);
      if (bus.REQ_I[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Next-state logic: one ISSUE cycle, then WAIT until done or the watchdog fires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.CORE_DONE_I || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation without a response.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant capture, watchdog timer and response registers.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_ptr      <= IW'(N_REQ - 1);
      r_id       <= '0;
      r_core_dat <= '0;
      r_timer    <= '0;
      r_resp_dat <= '0;
      r_resp_id  <= '0;
      r_resp_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_core_dat <= bus.REQ_DATA_I[w_winner*DW +: DW];
            r_id       <= w_winner;
            r_ptr      <= w_winner;
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          // Saturate: the timeout compare exits WAIT before any wrap could matter.
          if (!w_timeout) r_timer <= r_timer + 1'b1;
          // Done takes priority over a coincident timeout.
          if (bus.CORE_DONE_I) begin
            r_resp_dat <= bus.CORE_DATA_I;
            r_resp_err <= 1'b0;
            r_resp_id  <= r_id;
          end else if (w_timeout) begin
            r_resp_dat <= '0;
            r_resp_err <= 1'b1;
            r_resp_id  <= r_id;
          end
        end
        S_RESP:  r_resp_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ACK_O        = (r_state == S_ISSUE) ? (N_REQ'(1) << r_id) : '0;
  assign bus.CORE_START_O = (r_state == S_ISSUE);
  assign bus.CORE_DATA_O  = r_core_dat;
  assign bus.RESP_VALID_O = (r_state == S_RESP);
  assign bus.RESP_ERR_O   = r_resp_err;
  assign bus.RESP_DATA_O  = r_resp_dat;
  assign bus.RESP_ID_O    = r_resp_id;
  assign bus.BUSY_O       = (r_state != S_IDLE);
endmodule

// File: tb/tb_arcsin_sched.sv
// Scoreboard bench for arcsin_sched with a register-based core model of programmable latency.
// Stimulus pushes expected responses; a negedge monitor pops and compares each RESP strobe.
// Requests are held until ACK, then dropped.
module tb_arcsin_sched;
  localparam int N_REQ = 4;
  localparam int DW = 20;
  localparam int RW = 8;
  localparam int TIMEOUT = 64;

  typedef struct {
    int         id;
    logic [7:0] dat;
    bit         err;
    int         at;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t e_mon;

  logic [19:0] ops [4];

  // core model controls
  int         core_lat;
  bit         core_en;
  bit         core_fn;
  logic [7:0] core_res;
  logic       spur_done;

  logic       core_done_q;
  logic [7:0] core_dat_q;
  logic [19:0] core_cap;
  int         c_cnt;
  bit         c_run;

  arcsin_sched_if #(.N_REQ(N_REQ), .DW(DW), .RW(RW)) bus ();

  arcsin_sched #(.N_REQ(N_REQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
    .CLK_I  (clk),
    .RST_N_I(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core: done rises core_lat edges after START is sampled; reset by the same reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done_q <= 1'b0;
      core_dat_q  <= '0;
      core_cap    <= '0;
      c_cnt       <= 0;
      c_run       <= 1'b0;
    end else begin
      core_done_q <= 1'b0;
      if (bus.CORE_START_O) begin
        c_cnt    <= core_lat;
        c_run    <= core_en;
        core_cap <= bus.CORE_DATA_O;
      end else if (c_run) begin
        if (c_cnt <= 1) begin
          core_done_q <= 1'b1;
          core_dat_q  <= core_fn ? core_cap[7:0] : core_res;
          c_run       <= 1'b0;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
    end
  end

  assign bus.CORE_DONE_I = core_done_q | spur_done;
  assign bus.CORE_DATA_I = core_dat_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.RESP_VALID_O) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: got id=%0d data=%0h err=%0b expected none",
                 bus.RESP_ID_O, bus.RESP_DATA_O, bus.RESP_ERR_O);
      end else begin
        e_mon = exp_q.pop_front();
        chk("resp_id", 32'(bus.RESP_ID_O), 32'(e_mon.id));
        chk("resp_data", 32'(bus.RESP_DATA_O), 32'(e_mon.dat));
        chk("resp_err", 32'(bus.RESP_ERR_O), 32'(e_mon.err));
        if (e_mon.at >= 0) chk("resp_cycle", cyc, e_mon.at);
      end
    end
  end

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_ack(output logic [3:0] ack, output int at);
    ack = '0;
    at  = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.ACK_O != '0) begin
        ack = bus.ACK_O;
        at  = cyc;
        break;
      end
    end
  endtask

  // Single operation: raise mask, expect grant exp_id, response checked by the monitor.
  task automatic issue(input logic [3:0] mask, input int exp_id, input int lat, input bit en,
                       input bit fn, input logic [7:0] res, input logic [7:0] exp_dat,
                       input bit exp_err, input int exp_lat);
    exp_t e;
    logic [3:0] ack;
    int at;
    int c0;
    core_lat = lat;
    core_en  = en;
    core_fn  = fn;
    core_res = res;
    c0       = cyc;
    e.id = exp_id; e.dat = exp_dat; e.err = exp_err; e.at = c0 + exp_lat;
    exp_q.push_back(e);
    bus.REQ_I = mask;
    wait_ack(ack, at);
    chk("ack_onehot", 32'(ack), 32'(4'b0001 << exp_id));
    chk("ack_latency", at - c0, 1);
    chk("core_start", 32'(bus.CORE_START_O), 1);
    chk("core_data", 32'(bus.CORE_DATA_O), 32'(ops[exp_id]));
    bus.REQ_I = '0;
    @(posedge clk); #1;
    chk("ack_pulse", 32'({bus.ACK_O, bus.CORE_START_O}), 0);
    chk("busy_run", 32'(bus.BUSY_O), 1);
    wait_empty(200);
  endtask

  initial begin
    int rr_order [5];
    logic [3:0] ack;
    int at;
    exp_t e;
    rr_order = '{0, 1, 2, 3, 0};
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0;
    spur_done = 1'b0;
    core_lat = 1; core_en = 1'b1; core_fn = 1'b0; core_res = '0;
    ops[0] = 20'h36753; ops[1] = 20'hABC22; ops[2] = 20'h01233; ops[3] = 20'hFFF44;
    bus.REQ_I = '0;
    bus.REQ_DATA_I = {ops[3], ops[2], ops[1], ops[0]};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus.ACK_O), 0);
    chk("rst_valid", 32'(bus.RESP_VALID_O), 0);
    chk("rst_err", 32'(bus.RESP_ERR_O), 0);
    chk("rst_data", 32'(bus.RESP_DATA_O), 0);
    chk("rst_id", 32'(bus.RESP_ID_O), 0);
    chk("rst_start", 32'(bus.CORE_START_O), 0);
    chk("rst_core_data", 32'(bus.CORE_DATA_O), 0);
    chk("rst_busy", 32'(bus.BUSY_O), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spurious done while idle: nothing may happen.
    spur_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("spur_busy", 32'(bus.BUSY_O), 0);
      chk("spur_valid", 32'(bus.RESP_VALID_O), 0);
    end
    spur_done = 1'b0;
    @(posedge clk); #1;

    // Round-robin with all requesters held; core returns the operand low byte.
    core_lat = 2; core_en = 1'b1; core_fn = 1'b1;
    for (int g = 0; g < 5; g++) begin
      e.id = rr_order[g]; e.dat = ops[rr_order[g]][7:0]; e.err = 1'b0; e.at = -1;
      exp_q.push_back(e);
    end
    bus.REQ_I = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_ack(ack, at);
      chk("rr_grant", 32'(ack), 32'(4'b0001 << rr_order[g]));
      chk("rr_core_data", 32'(bus.CORE_DATA_O), 32'(ops[rr_order[g]]));
      if (g == 4) bus.REQ_I = '0;
    end
    wait_empty(200);

    // Single request, L=10: response 13 cycles after the request is presented.
    issue(4'b0001, 0, 10, 1'b1, 1'b0, 8'h2A, 8'h2A, 1'b0, 13);

    // Core never answers: error response 66 cycles after request presentation.
    issue(4'b0100, 2, 1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, TIMEOUT + 2);
    // Next request served normally.
    issue(4'b0010, 1, 3, 1'b1, 1'b0, 8'h5C, 8'h5C, 1'b0, 6);

    // Done on the same cycle as the timeout: done wins.
    issue(4'b1000, 3, TIMEOUT - 1, 1'b1, 1'b0, 8'h77, 8'h77, 1'b0, TIMEOUT + 2);

    // Done one cycle too late: timeout; the late done lands in RESP and is ignored.
    issue(4'b0001, 0, TIMEOUT, 1'b1, 1'b0, 8'h99, 8'h00, 1'b1, TIMEOUT + 2);
    repeat (5) @(posedge clk);
    #1;

    // Reset while in WAIT: outputs clear at once, no response.
    core_lat = 20; core_en = 1'b1; core_fn = 1'b0; core_res = 8'hEE;
    bus.REQ_I = 4'b0010;
    wait_ack(ack, at);
    chk("wrst_grant", 32'(ack), 32'(4'b0010));
    bus.REQ_I = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("wrst_busy", 32'(bus.BUSY_O), 0);
    chk("wrst_valid", 32'(bus.RESP_VALID_O), 0);
    chk("wrst_outs", 32'({bus.ACK_O, bus.CORE_START_O, bus.RESP_ERR_O, bus.RESP_ID_O}), 0);
    chk("wrst_resp_data", 32'(bus.RESP_DATA_O), 0);
    chk("wrst_core_data", 32'(bus.CORE_DATA_O), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("wrst_idle", 32'(bus.BUSY_O), 0);

    // Pointer restarted: requester 0 beats requester 3.
    issue(4'b1001, 0, 2, 1'b1, 1'b1, 8'h00, ops[0][7:0], 1'b0, 5);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
